// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM states, default latencies.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 6..9).
package mdu_pkg;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Ops that occupy the unit for a latency window (as opposed to MTHI/MTLO).
   function automatic logic is_muldiv(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op <= OP_DIVU) || ((op >= OP_MADD) && (op <= OP_MSUBU));
`else
      return (op <= OP_DIVU);
`endif
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: computes the next {hi,lo} for the latched op.
// MDU_MADD_EN adds the accumulate/subtract forms, which use the live hi/lo.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] hi_nxt,
   output logic [31:0] lo_nxt,
   output logic        div_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] mag_b_safe;
   logic [31:0] b_safe;
   logic [31:0] uq;
   logic [31:0] ur;

   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'd0, a} * {32'd0, b};

      // Signed divide on magnitudes; 0x80000000 negates to itself, which gives the required overflow result.
      mag_a      = a[31] ? -a : a;
      mag_b      = b[31] ? -b : b;
      mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
      b_safe     = (b == 32'd0) ? 32'd1 : b;
      uq         = mag_a / mag_b_safe;
      ur         = mag_a % mag_b_safe;

      hi_nxt   = hi;
      lo_nxt   = lo;
      div_zero = 1'b0;

      case (op)
         OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
         OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
         OP_DIV: begin
            if (b == 32'd0) begin
               div_zero = 1'b1;
            end else begin
               lo_nxt = (a[31] ^ b[31]) ? -uq : uq;
               hi_nxt = a[31] ? -ur : ur;
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) begin
               div_zero = 1'b1;
            end else begin
               lo_nxt = a / b_safe;
               hi_nxt = a % b_safe;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {hi_nxt, lo_nxt} = {hi, lo} + prod_s;
         OP_MADDU: {hi_nxt, lo_nxt} = {hi, lo} + prod_u;
         OP_MSUB:  {hi_nxt, lo_nxt} = {hi, lo} - prod_s;
         OP_MSUBU: {hi_nxt, lo_nxt} = {hi, lo} - prod_u;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: accepts ops from E, runs a fixed-latency busy window, commits HI/LO at its end.
// Build with MDU_MADD_EN to enable the MADD/MSUB family (codes 6..9, MULT_LAT latency).
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        dz
);

   localparam logic [3:0] MULT_CNT = MULT_LAT[3:0];
   localparam logic [3:0] DIV_CNT  = DIV_LAT[3:0];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] rs_q, rs_d;
   logic [31:0] rt_q, rt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;

   logic        accept;
   logic [31:0] arith_hi;
   logic [31:0] arith_lo;
   logic        arith_dz;

   mdu_arith u_arith (
      .op       (op_q),
      .a        (rs_q),
      .b        (rt_q),
      .hi       (hi_q),
      .lo       (lo_q),
      .hi_nxt   (arith_hi),
      .lo_nxt   (arith_lo),
      .div_zero (arith_dz)
   );

   assign accept = start & ~flush & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op == OP_MTHI) begin
                  hi_d = rs_data;
               end else if (op == OP_MTLO) begin
                  lo_d = rs_data;
               end else if (is_muldiv(op)) begin
                  op_d    = op;
                  rs_d    = rs_data;
                  rt_d    = rt_data;
                  cnt_d   = is_div(op) ? DIV_CNT : MULT_CNT;
                  state_d = RUN;
                  busy_d  = 1'b1;
                  if (is_div(op)) begin
                     dz_d = 1'b0;
                  end
               end
            end
         end
         RUN: begin
            // Start and flush are both ignored here; the running op always completes.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (arith_dz) begin
                  dz_d = 1'b1;
               end else begin
                  hi_d = arith_hi;
                  lo_d = arith_lo;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 4'd0;
         rs_q    <= 32'd0;
         rt_q    <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random traffic against a behavioural model.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int MLAT = 5;
   localparam int DLAT = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        dz;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo),
      .dz      (dz)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Behavioural model: a pending op completes at an absolute cycle number.
   int          cyc = 0;
   bit          m_pend;
   int          m_commit_at;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b;
   logic [31:0] m_hi, m_lo;
   bit          m_dz, m_done;

   function automatic void model_reset();
      m_pend = 0; m_commit_at = 0; m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0; m_dz = 0; m_done = 0;
   endfunction

   function automatic void model_commit();
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p, acc;
      sa = $signed(m_a);
      sb = $signed(m_b);
      ua = m_a;
      ub = m_b;
      acc = {m_hi, m_lo};
      case (m_op)
         OP_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
         OP_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; end
         OP_DIV: begin
            if (m_b == 32'd0) m_dz = 1;
            else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
         end
         OP_DIVU: begin
            if (m_b == 32'd0) m_dz = 1;
            else begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin p = sa * sb; acc = acc + p; {m_hi, m_lo} = acc; end
         OP_MADDU: begin p = ua * ub; acc = acc + p; {m_hi, m_lo} = acc; end
         OP_MSUB:  begin p = sa * sb; acc = acc - p; {m_hi, m_lo} = acc; end
         OP_MSUBU: begin p = ua * ub; acc = acc - p; {m_hi, m_lo} = acc; end
`endif
         default: ;
      endcase
   endfunction

   function automatic int model_latency(input logic [3:0] o);
      case (o)
         OP_MULT, OP_MULTU: return MLAT;
         OP_DIV, OP_DIVU:   return DLAT;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MLAT;
`endif
         default: return 0;
      endcase
   endfunction

   function automatic void model_edge();
      cyc++;
      m_done = 0;
      if (m_pend) begin
         if (cyc == m_commit_at) begin
            m_pend = 0;
            m_done = 1;
            model_commit();
         end
      end else if (start && !flush) begin
         if (op == OP_MTHI) m_hi = rs_data;
         else if (op == OP_MTLO) m_lo = rs_data;
         else if (model_latency(op) > 0) begin
            m_pend = 1;
            m_commit_at = cyc + model_latency(op);
            m_op = op; m_a = rs_data; m_b = rt_data;
            if (op == OP_DIV || op == OP_DIVU) m_dz = 0;
         end
      end
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic checkOutput();
      check("busy", {31'd0, busy}, {31'd0, m_pend});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("dz", {31'd0, dz}, {31'd0, m_dz});
   endtask

   task automatic applyStimulus(input logic s, input logic [3:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic f);
      @(negedge clk);
      start = s; op = o; rs_data = a; rt_data = b; flush = f;
      @(posedge clk);
      model_edge();
      #1;
      checkOutput();
   endtask

   // Issues an op and counts the busy cycles that follow, bounded.
   task automatic runAndCount(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              output int nb);
      applyStimulus(1'b1, o, a, b, 1'b0);
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         nb++;
         applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      end
   endtask

   int nb;

   initial begin
      model_reset();
      #12;
      checkOutput();
      @(negedge clk);
      reset = 1'b1;

      runAndCount(OP_MULT, 32'hFFFFFFFE, 32'd3, nb);
      check("mult_busy_cycles", nb, MLAT);
      check("mult_done", {31'd0, done}, 32'd1);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFA);

      runAndCount(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);

      runAndCount(OP_DIV, 32'hFFFFFFF9, 32'd2, nb);
      check("div_busy_cycles", nb, DLAT);
      check("div_lo", lo, 32'hFFFFFFFD);
      check("div_hi", hi, 32'hFFFFFFFF);

      runAndCount(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
      check("div_ovf_lo", lo, 32'h80000000);
      check("div_ovf_hi", hi, 32'h00000000);

      applyStimulus(1'b1, OP_MTHI, 32'h12345678, 32'd0, 1'b1);
      check("mthi_flushed_hi", hi, 32'h00000000);
      applyStimulus(1'b1, OP_MTHI, 32'h12345678, 32'd0, 1'b0);
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

      applyStimulus(1'b1, OP_MTHI, 32'hA, 32'd0, 1'b0);
      applyStimulus(1'b1, OP_MTLO, 32'hB, 32'd0, 1'b0);
      runAndCount(OP_DIVU, 32'd5, 32'd0, nb);
      check("divz_busy_cycles", nb, DLAT);
      check("divz_done", {31'd0, done}, 32'd1);
      check("divz_hi", hi, 32'hA);
      check("divz_lo", lo, 32'hB);
      check("divz_dz", {31'd0, dz}, 32'd1);
      runAndCount(OP_DIVU, 32'd9, 32'd2, nb);
      check("divu_lo", lo, 32'd4);
      check("divu_hi", hi, 32'd1);
      check("divu_dz", {31'd0, dz}, 32'd0);

      // Reset in the middle of a divide.
      applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      checkOutput();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      runAndCount(OP_MULTU, 32'd6, 32'd7, nb);
      check("post_rst_lo", lo, 32'd42);

      // Random traffic, including starts/flushes during RUN and undefined ops.
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a, b;
         logic        s, f;
         logic [3:0]  o;
         s = ($urandom_range(0, 9) < 4);
         f = ($urandom_range(0, 9) < 2);
         o = 4'($urandom_range(0, 11));
         a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         applyStimulus(s, o, a, b, f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and latches the operands. Sequences a fixed-latency busy window and commits HI/LO at the end of that window. Exports busy so D-stage hazard logic stalls any mult/div/mfhi/mflo/mthi/mtlo while the unit is occupied, and accepts a flush that cancels a start coinciding with an exception.

Parameters:
MULT_LAT, 5, busy cycles for MULT/MULTU (and MADD-family when enabled); legal range 1..15
DIV_LAT, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is an MDU op this cycle
op  input  4  operation code; encodings in mdu_pkg
rs_data  input  32  forwarded rs operand
rt_data  input  32  forwarded rt operand
flush  input  1  exception request this cycle; suppresses start
busy  output  1  unit occupied, registered
done  output  1  one-cycle pulse on the cycle HI/LO first show a new mult/div result
hi  output  32  HI register
lo  output  32  LO register
dz  output  1  sticky flag: last DIV/DIVU had a zero divisor; cleared by next accepted DIV/DIVU

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, dz=0, operand latches=0.
- States: IDLE, RUN.
- Accept = start & ~flush & (state==IDLE). Start with flush=1 has no effect at all.
- IDLE, accept, op=MTHI/MTLO: hi or lo <= rs_data at this edge. State stays IDLE, busy stays 0, no done.
- IDLE, accept, mult/div op: latch rs/rt/op, cnt <= LAT, state <= RUN. busy=1 from the next cycle.
- RUN: cnt decrements each edge. At the edge where cnt==1: hi/lo commit, state <= IDLE, busy <= 0, done <= 1 for one cycle.
- busy is high for exactly LAT cycles. New hi/lo are visible in the same cycle busy falls.
- start while in RUN: ignored. Upstream guarantees this never happens via stall. The bench checks that hi/lo stay unaffected.
- flush while in RUN: ignored. The running op is older than the faulting instruction and completes.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divisor==0 (DIV/DIVU): full latency still runs and done still pulses; hi/lo keep their old values; dz <= 1.
- Undefined op with accept: treated as no-op, no state change.
- Reset asserted mid-RUN: immediate return to the reset values; the partial operation is discarded.

Optional Feature:
MDU_MADD_EN
- Defined: adds MADD=6, MADDU=7, MSUB=8, MSUBU=9, each with MULT_LAT.
  - Commit is {hi,lo} <= {hi,lo} ± product (signed or unsigned), modulo 2^64.
  - The accumulate uses the {hi,lo} value present at commit.
- Undefined: codes 6..9 are undefined ops (no-op).

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD..MSUBU=6..9
  - state enum {IDLE, RUN}
  - default latencies 5/10
- One combinational sub-module, mdu_arith:
  - inputs: latched op, operands, current hi/lo
  - outputs: next {hi,lo} and a zero-divisor flag
  - keeps the FSM/counter in mdu_ctrl free of arithmetic.

Test Plan:
- MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678 with flush=1 -> hi unchanged, busy=0. Same with flush=0 -> hi=0x12345678 next cycle, busy never rises.
- DIVU rt=0 with hi=0xA, lo=0xB -> 10 busy cycles, done=1, hi/lo unchanged, dz=1. Next DIVU 9/2 -> lo=4, hi=1, dz=0.
- Start DIV, pull reset=0 at busy cycle 4 -> busy, hi, lo, dz all 0 immediately. Start accepted normally after release.
